// File: rtl/proc_bus_pkg.sv
// proc_bus_pkg: shared FSM encoding and source-index helpers for the bus driver.
// Revision 1.0
`default_nettype none

package proc_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_FAULT = 2'd2
    } bus_state_e;

    // Registers occupy indices 0..nregs-1; the two external sources sit just above them.
    function automatic int idx_din(input int nregs);
        return nregs;
    endfunction

    function automatic int idx_g(input int nregs);
        return nregs + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_onehot_enc.sv
// proc_onehot_enc: classifies a select vector as none/one/many and encodes the set bit.
// Revision 1.0
`default_nettype none

module proc_onehot_enc #(
    parameter int N  = 10,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  sel,
    output logic          none,
    output logic          one,
    output logic          many,
    output logic [IW-1:0] idx
);

    logic [1:0] cnt;

    // idx is only meaningful when exactly one bit is set; OR-ing keeps it a pure encoder.
    always_comb begin
        cnt = 2'd0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                idx = idx | IW'(i);
                if (cnt != 2'd2) begin
                    cnt = cnt + 2'd1;
                end
            end
        end
    end

    assign none = (cnt == 2'd0);
    assign one  = (cnt == 2'd1);
    assign many = (cnt == 2'd2);

endmodule

`default_nettype wire

// File: rtl/proc_bus_driver.sv
// proc_bus_driver: registered processor bus with keeper, single-source check and conflict tracking.
// Revision 1.0
`default_nettype none

module proc_bus_driver
    import proc_bus_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NREGS = 8,
    parameter int CNTW  = 4
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          Gout,
    input  logic                          DINout,
    input  logic [NREGS-1:0]              Rout,
    input  logic [WIDTH-1:0]              G,
    input  logic [WIDTH-1:0]              DIN,
    input  logic [NREGS*WIDTH-1:0]        R,
    input  logic                          ErrClr,
    output logic [WIDTH-1:0]              Bus,
    output logic                          BusValid,
    output logic [$clog2(NREGS+2)-1:0]    SrcIdx,
    output logic                          Conflict,
    output logic [CNTW-1:0]               ConflictCnt
);

    localparam int NSRC    = NREGS + 2;
    localparam int IW      = $clog2(NSRC);
    localparam int IDX_DIN = idx_din(NREGS);
    localparam int IDX_G   = idx_g(NREGS);

    logic [NSRC-1:0]  sel;
    logic             sel_none;
    logic             sel_one;
    logic             sel_many;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] mux_data;
    bus_state_e       state;

    // Rout is MSB-first: Rout[NREGS-1] selects R0.
    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_sel
            assign sel[i] = Rout[NREGS-1-i];
        end
    endgenerate

    assign sel[IDX_DIN] = DINout;
    assign sel[IDX_G]   = Gout;

    proc_onehot_enc #(
        .N  (NSRC),
        .IW (IW)
    ) u_enc (
        .sel  (sel),
        .none (sel_none),
        .one  (sel_one),
        .many (sel_many),
        .idx  (sel_idx)
    );

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
                mux_data = mux_data | R[i*WIDTH +: WIDTH];
            end
        end
        if (DINout) begin
            mux_data = mux_data | DIN;
        end
        if (Gout) begin
            mux_data = mux_data | G;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Bus         <= '0;
            BusValid    <= 1'b0;
            SrcIdx      <= '0;
            Conflict    <= 1'b0;
            ConflictCnt <= '0;
            state       <= S_IDLE;
        end else if (sel_many) begin
            // A conflict outranks ErrClr: the counter restarts at one instead of clearing.
            BusValid <= 1'b0;
            Conflict <= 1'b1;
            state    <= S_FAULT;
            if (ErrClr) begin
                ConflictCnt <= CNTW'(1);
            end else if (!(&ConflictCnt)) begin
                ConflictCnt <= ConflictCnt + CNTW'(1);
            end
        end else begin
            if (ErrClr) begin
                Conflict    <= 1'b0;
                ConflictCnt <= '0;
            end
            BusValid <= sel_one;
            if (sel_one) begin
                Bus    <= mux_data;
                SrcIdx <= sel_idx;
            end
            if (state != S_FAULT || ErrClr) begin
                state <= sel_none ? S_IDLE : S_DRIVE;
            end
        end
    end

endmodule

`default_nettype wire
